// File: rtl/note_seq_pkg.sv
// Shared types and default widths for the note sequencer slice.
package note_seq_pkg;

    localparam int PITCH_W_DEF   = 9;
    localparam int DUR_W_DEF     = 13;
    localparam int ADDR_W_DEF    = 5;
    localparam int GAP_TICKS_DEF = 8;

    // Idle pitch at the default width; the top drives all ones for any PITCH_W.
    localparam logic [PITCH_W_DEF-1:0] IDLE_PITCH = 9'd511;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP
    } seq_state_e;

endpackage

// File: rtl/note_mem.sv
// Note storage: one synchronous write port, one asynchronous read port.
module note_mem #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 23
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Contents survive reset; a same-cycle read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/note_sequencer.sv
// Plays a programmed list of {pitch, duration, last} notes against the fs_tick strobe.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int PITCH_W   = PITCH_W_DEF,
    parameter int DUR_W     = DUR_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int GAP_TICKS = GAP_TICKS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fs_tick,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PITCH_W-1:0] wr_pitch,
    input  logic [DUR_W-1:0]   wr_dur,
    input  logic               wr_last,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    output logic [PITCH_W-1:0] pitch_o,
    output logic               tone_restart,
    output logic               mute_o,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  cur_idx
);

    localparam int DATA_W     = PITCH_W + DUR_W + 1;
    localparam int GAP_W      = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int CNT_W      = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam int GAP_LAST_I = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LAST_I);

    seq_state_e         state_q;
    logic [ADDR_W-1:0]  cur_idx_q;
    logic [PITCH_W-1:0] pitch_q;
    logic [DUR_W-1:0]   dur_q;
    logic               last_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mute_q;
    logic               tone_q;
    logic               done_q;

    logic [DATA_W-1:0]  rd_data;
    logic [PITCH_W-1:0] rd_pitch;
    logic [DUR_W-1:0]   rd_dur;
    logic               rd_last;

    note_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i ({wr_last, wr_dur, wr_pitch}),
        .rd_addr_i (cur_idx_q),
        .rd_data_o (rd_data)
    );

    assign rd_pitch = rd_data[PITCH_W-1:0];
    assign rd_dur   = rd_data[PITCH_W +: DUR_W];
    assign rd_last  = rd_data[DATA_W-1];

    // A zero duration plays for one tick, so the final count is max(dur,1)-1.
    logic [DUR_W-1:0] dur_last;
    logic             play_end;
    logic             gap_end;
    assign dur_last = (dur_q == '0) ? '0 : dur_q - DUR_W'(1);
    assign play_end = fs_tick && (cnt_q == CNT_W'(dur_last));
    assign gap_end  = fs_tick && (cnt_q == GAP_LAST);

    seq_state_e        adv_state_d;
    logic [ADDR_W-1:0] adv_idx_d;
    logic              adv_done_d;

    always_comb begin
        adv_state_d = ST_LOAD;
        adv_idx_d   = cur_idx_q + ADDR_W'(1);
        adv_done_d  = 1'b0;
        if (last_q || (&cur_idx_q)) begin
            adv_idx_d = '0;
            if (!loop_en) begin
                adv_state_d = ST_IDLE;
                adv_done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cur_idx_q <= '0;
            pitch_q   <= '1;
            dur_q     <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            mute_q    <= 1'b1;
            tone_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tone_q <= 1'b0;
            done_q <= 1'b0;
            if (stop) begin
                state_q <= ST_IDLE;
                pitch_q <= '1;
                mute_q  <= 1'b1;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            cur_idx_q <= '0;
                            state_q   <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        pitch_q <= rd_pitch;
                        dur_q   <= rd_dur;
                        last_q  <= rd_last;
                        cnt_q   <= '0;
                        mute_q  <= (rd_pitch == '0);
                        tone_q  <= 1'b1;
                        state_q <= ST_PLAY;
                    end
                    ST_PLAY, ST_GAP: begin
                        if ((state_q == ST_PLAY && play_end) ||
                            (state_q == ST_GAP && gap_end)) begin
                            cnt_q <= '0;
                            if (state_q == ST_PLAY && GAP_TICKS > 0) begin
                                state_q <= ST_GAP;
                                mute_q  <= 1'b1;
                            end else begin
                                state_q   <= adv_state_d;
                                cur_idx_q <= adv_idx_d;
                                done_q    <= adv_done_d;
                                if (adv_state_d == ST_IDLE) begin
                                    pitch_q <= '1;
                                    mute_q  <= 1'b1;
                                end
                            end
                        end else if (fs_tick) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign pitch_o      = pitch_q;
    assign tone_restart = tone_q;
    assign mute_o       = mute_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign cur_idx      = cur_idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a legato instance and an 8-tick-gap instance share stimulus.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fs_tick = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [8:0] wr_pitch = '0;
    logic [12:0] wr_dur = '0;
    logic       wr_last = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;

    logic [8:0] pitch0, pitch8;
    logic       tone0, tone8, mute0, mute8, busy0, busy8, done0, done8;
    logic [4:0] cur0, cur8;

    int vectors = 0;
    int errors  = 0;
    int done_cnt0 = 0;
    int done_cnt8 = 0;

    always #5 clk = ~clk;

    note_sequencer #(.GAP_TICKS(0)) dut0 (
        .clk(clk), .reset(reset), .fs_tick(fs_tick), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_pitch(wr_pitch), .wr_dur(wr_dur), .wr_last(wr_last), .start(start), .stop(stop),
        .loop_en(loop_en), .pitch_o(pitch0), .tone_restart(tone0), .mute_o(mute0),
        .busy(busy0), .done(done0), .cur_idx(cur0)
    );

    note_sequencer #(.GAP_TICKS(8)) dut8 (
        .clk(clk), .reset(reset), .fs_tick(fs_tick), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_pitch(wr_pitch), .wr_dur(wr_dur), .wr_last(wr_last), .start(start), .stop(stop),
        .loop_en(loop_en), .pitch_o(pitch8), .tone_restart(tone8), .mute_o(mute8),
        .busy(busy8), .done(done8), .cur_idx(cur8)
    );

    always @(posedge clk) begin
        if (done0 === 1'b1) done_cnt0++;
        if (done8 === 1'b1) done_cnt8++;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic give_tick();
        fs_tick = 1'b1;
        step();
        fs_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic write_note(input int a, input int p, input int d, input bit l);
        wr_en = 1'b1; wr_addr = 5'(a); wr_pitch = 9'(p); wr_dur = 13'(d); wr_last = l;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (pitch0 !== 9'd511) begin errors++; $display("FAIL rst_pitch: got %0d want 511", pitch0); end
        vectors++; if (mute0 !== 1'b1) begin errors++; $display("FAIL rst_mute: got %b want 1", mute0); end
        vectors++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy0); end
        vectors++; if (done0 !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done0); end
        vectors++; if (tone0 !== 1'b0) begin errors++; $display("FAIL rst_tone: got %b want 0", tone0); end
        vectors++; if (cur0 !== 5'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", cur0); end
    endtask

    task automatic test_basic();
        int d;
        do_reset();
        write_note(0, 199, 4, 0);
        write_note(1, 177, 2, 1);
        loop_en = 1'b0;
        d = done_cnt0;
        pulse_start();
        vectors++; if (tone0 !== 1'b0) begin errors++; $display("FAIL basic_tone_early: got %b want 0", tone0); end
        vectors++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy_load: got %b want 1", busy0); end
        step();
        vectors++; if (tone0 !== 1'b1) begin errors++; $display("FAIL basic_tone_lat2: got %b want 1", tone0); end
        vectors++; if (pitch0 !== 9'd199) begin errors++; $display("FAIL basic_pitch0: got %0d want 199", pitch0); end
        vectors++; if (mute0 !== 1'b0) begin errors++; $display("FAIL basic_mute0: got %b want 0", mute0); end
        step();
        vectors++; if (tone0 !== 1'b0) begin errors++; $display("FAIL basic_tone_width: got %b want 0", tone0); end
        repeat (3) begin give_tick(); step(); end
        vectors++; if (pitch0 !== 9'd199) begin errors++; $display("FAIL basic_hold3: got %0d want 199", pitch0); end
        give_tick();
        step();
        vectors++; if (pitch0 !== 9'd177) begin errors++; $display("FAIL basic_pitch1: got %0d want 177", pitch0); end
        vectors++; if (tone0 !== 1'b1) begin errors++; $display("FAIL basic_tone1: got %b want 1", tone0); end
        vectors++; if (cur0 !== 5'd1) begin errors++; $display("FAIL basic_idx1: got %0d want 1", cur0); end
        give_tick();
        step();
        vectors++; if (done0 !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %b want 0", done0); end
        give_tick();
        vectors++; if (done0 !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done0); end
        vectors++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy0); end
        vectors++; if (pitch0 !== 9'd511) begin errors++; $display("FAIL basic_pitch_idle: got %0d want 511", pitch0); end
        vectors++; if (mute0 !== 1'b1) begin errors++; $display("FAIL basic_mute_idle: got %b want 1", mute0); end
        step();
        vectors++; if (done0 !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done0); end
        vectors++; if (done_cnt0 !== d + 1) begin errors++; $display("FAIL basic_done_count: got %0d want %0d", done_cnt0, d + 1); end
    endtask

    task automatic test_loop();
        int d;
        do_reset();
        loop_en = 1'b1;
        d = done_cnt0;
        pulse_start();
        step();
        vectors++; if (pitch0 !== 9'd199) begin errors++; $display("FAIL loop_mem_kept: got %0d want 199", pitch0); end
        repeat (4) begin give_tick(); step(); end
        vectors++; if (pitch0 !== 9'd177) begin errors++; $display("FAIL loop_pitch1: got %0d want 177", pitch0); end
        repeat (2) begin give_tick(); step(); end
        vectors++; if (pitch0 !== 9'd199) begin errors++; $display("FAIL loop_wrap_pitch: got %0d want 199", pitch0); end
        vectors++; if (cur0 !== 5'd0) begin errors++; $display("FAIL loop_wrap_idx: got %0d want 0", cur0); end
        vectors++; if (busy0 !== 1'b1) begin errors++; $display("FAIL loop_busy: got %b want 1", busy0); end
        vectors++; if (done_cnt0 !== d) begin errors++; $display("FAIL loop_no_done: got %0d want %0d", done_cnt0, d); end
        loop_en = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_rest();
        do_reset();
        write_note(0, 0, 3, 1);
        pulse_start();
        step();
        vectors++; if (tone0 !== 1'b1) begin errors++; $display("FAIL rest_tone: got %b want 1", tone0); end
        vectors++; if (pitch0 !== 9'd0) begin errors++; $display("FAIL rest_pitch: got %0d want 0", pitch0); end
        vectors++; if (mute0 !== 1'b1) begin errors++; $display("FAIL rest_mute0: got %b want 1", mute0); end
        repeat (2) begin
            give_tick();
            step();
            vectors++; if (mute0 !== 1'b1 || busy0 !== 1'b1) begin errors++; $display("FAIL rest_mute_play: got mute=%b busy=%b want 1 1", mute0, busy0); end
        end
        give_tick();
        vectors++; if (done0 !== 1'b1) begin errors++; $display("FAIL rest_done: got %b want 1", done0); end
        step();
    endtask

    task automatic test_gap();
        int d8;
        do_reset();
        write_note(0, 199, 4, 0);
        write_note(1, 177, 2, 1);
        d8 = done_cnt8;
        pulse_start();
        step();
        vectors++; if (pitch8 !== 9'd199 || mute8 !== 1'b0) begin errors++; $display("FAIL gap_note0: got pitch=%0d mute=%b want 199 0", pitch8, mute8); end
        step();
        repeat (3) begin give_tick(); step(); end
        vectors++; if (mute8 !== 1'b0) begin errors++; $display("FAIL gap_early_mute: got %b want 0", mute8); end
        give_tick();
        vectors++; if (mute8 !== 1'b1) begin errors++; $display("FAIL gap_enter: got %b want 1", mute8); end
        step();
        repeat (7) begin give_tick(); step(); end
        vectors++; if (mute8 !== 1'b1 || busy8 !== 1'b1) begin errors++; $display("FAIL gap_after7: got mute=%b busy=%b want 1 1", mute8, busy8); end
        vectors++; if (cur8 !== 5'd0) begin errors++; $display("FAIL gap_idx_hold: got %0d want 0", cur8); end
        give_tick();
        vectors++; if (mute8 !== 1'b1 || cur8 !== 5'd1) begin errors++; $display("FAIL gap_load: got mute=%b idx=%0d want 1 1", mute8, cur8); end
        step();
        vectors++; if (pitch8 !== 9'd177 || mute8 !== 1'b0 || tone8 !== 1'b1) begin errors++; $display("FAIL gap_note1: got pitch=%0d mute=%b tone=%b want 177 0 1", pitch8, mute8, tone8); end
        repeat (2) begin give_tick(); step(); end
        vectors++; if (mute8 !== 1'b1 || busy8 !== 1'b1) begin errors++; $display("FAIL gap_second: got mute=%b busy=%b want 1 1", mute8, busy8); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++; if (pitch8 !== 9'd511 || mute8 !== 1'b1 || busy8 !== 1'b0) begin errors++; $display("FAIL gap_reset_a: got pitch=%0d mute=%b busy=%b want 511 1 0", pitch8, mute8, busy8); end
        vectors++; if (done8 !== 1'b0 || tone8 !== 1'b0 || cur8 !== 5'd0) begin errors++; $display("FAIL gap_reset_b: got done=%b tone=%b idx=%0d want 0 0 0", done8, tone8, cur8); end
        step(2);
        vectors++; if (done_cnt8 !== d8) begin errors++; $display("FAIL gap_reset_no_done: got %0d want %0d", done_cnt8, d8); end
    endtask

    task automatic test_stop();
        int d;
        do_reset();
        d = done_cnt0;
        pulse_start();
        step();
        give_tick();
        step();
        stop = 1'b1; start = 1'b1; fs_tick = 1'b1;
        step();
        stop = 1'b0; start = 1'b0; fs_tick = 1'b0;
        vectors++; if (busy0 !== 1'b0 || pitch0 !== 9'd511) begin errors++; $display("FAIL stop_idle: got busy=%b pitch=%0d want 0 511", busy0, pitch0); end
        vectors++; if (mute0 !== 1'b1 || tone0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL stop_outs: got mute=%b tone=%b done=%b want 1 0 0", mute0, tone0, done0); end
        step(3);
        vectors++; if (busy0 !== 1'b0 || done_cnt0 !== d) begin errors++; $display("FAIL stop_stays: got busy=%b dones=%0d want 0 %0d", busy0, done_cnt0, d); end
    endtask

    task automatic test_wrap();
        int d;
        int exp_p;
        do_reset();
        for (int i = 0; i < 32; i++) write_note(i, 100 + i, (i == 5) ? 0 : 1, 0);
        loop_en = 1'b1;
        d = done_cnt0;
        pulse_start();
        step();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 32; i++) begin
                exp_p = (p == 1 && i == 3) ? 300 : 100 + i;
                vectors++; if (pitch0 !== 9'(exp_p) || cur0 !== 5'(i)) begin errors++; $display("FAIL wrap_note p%0d: got pitch=%0d idx=%0d want %0d %0d", p, pitch0, cur0, exp_p, i); end
                if (p == 1 && i == 31) begin
                    loop_en = 1'b0;
                    give_tick();
                    vectors++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL wrap_done: got done=%b busy=%b want 1 0", done0, busy0); end
                end else begin
                    give_tick();
                    if (p == 0 && i == 2) begin
                        wr_en = 1'b1; wr_addr = 5'd3; wr_pitch = 9'd300; wr_dur = 13'd1; wr_last = 1'b0;
                    end
                    step();
                    wr_en = 1'b0;
                end
            end
        end
        step();
        vectors++; if (done_cnt0 !== d + 1) begin errors++; $display("FAIL wrap_done_count: got %0d want %0d", done_cnt0, d + 1); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_loop();
        test_rest();
        test_gap();
        test_stop();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter PITCH_W, default 9, meaning the pitch/clkgen maxval width.
REQ-002 SHALL have parameter DUR_W, default 13, meaning the note duration width in fs ticks.
REQ-003 SHALL have parameter ADDR_W, default 5, meaning the note memory address width (DEPTH = 2**ADDR_W = 32).
REQ-004 SHALL have parameter GAP_TICKS, default 8, meaning the muted fs ticks between notes (0 = legato).
REQ-005 SHALL have ports, one per line as name direction width meaning:
  clk  in  1  clock
  reset  in  1  reset, synchronous, active-high
  fs_tick  in  1  one-cycle sample strobe (8 kHz)
  wr_en  in  1  note memory write strobe
  wr_addr  in  ADDR_W  write address
  wr_pitch  in  PITCH_W  pitch maxval; 0 = rest
  wr_dur  in  DUR_W  duration in fs ticks
  wr_last  in  1  end-of-sequence marker
  start  in  1  begin playback at index 0
  stop  in  1  abort playback
  loop_en  in  1  wrap to index 0 after last note
  pitch_o  out  PITCH_W  maxval to the sine clkgen
  tone_restart  out  1  one-cycle pulse resetting sine/DAC/clkgen
  mute_o  out  1  silence DAC outputs
  busy  out  1  state != IDLE
  done  out  1  one-cycle pulse at sequence end
  cur_idx  out  ADDR_W  index of current note

Function
REQ-006 SHALL implement states IDLE, LOAD, PLAY, GAP.
REQ-007 SHALL, in IDLE, hold pitch_o = all ones (511), mute_o = 1, busy = 0.
REQ-008 SHALL, on start in IDLE, set cur_idx = 0 and enter LOAD next cycle; start outside IDLE is ignored.
REQ-009 SHALL spend exactly one cycle in LOAD, latching pitch, duration, last from mem[cur_idx] and clearing the tick counter.
REQ-010 SHALL, on the LOAD->PLAY edge, update pitch_o and pulse tone_restart for exactly the first PLAY cycle.
REQ-011 SHALL drive mute_o = 1 in PLAY when latched pitch == 0, else 0.
REQ-012 SHALL treat duration 0 as 1.
REQ-013 SHALL leave PLAY on the dur-th fs_tick observed in PLAY: to GAP if GAP_TICKS > 0, else advance directly.
REQ-014 SHALL hold mute_o = 1 in GAP and advance on the GAP_TICKS-th fs_tick observed in GAP.
REQ-015 SHALL advance as follows: if latched last = 1 or cur_idx = DEPTH-1, then with loop_en (sampled at that cycle) set cur_idx = 0 and go to LOAD, else pulse done and go to IDLE; otherwise increment cur_idx and go to LOAD.
REQ-016 SHALL give stop priority over start and fs_tick: any state -> IDLE next cycle, no done pulse, no tone_restart.
REQ-017 SHALL accept writes in every state; a note already latched is unaffected until its next LOAD.
REQ-018 SHALL return old data to a LOAD coinciding with a write to the same address (read-before-write).
REQ-019 SHALL ignore fs_tick in IDLE and LOAD.
REQ-020 SHALL produce the start->tone_restart latency of exactly 2 cycles.

Reset
REQ-021 SHALL set state = IDLE, pitch_o = 511, mute_o = 1, busy = 0, done = 0, tone_restart = 0, cur_idx = 0, and counters = 0 on reset, including mid-playback.
REQ-022 SHALL NOT clear note memory contents on reset.

Structure
REQ-023 SHALL place the state enum, IDLE_PITCH = 511, and the default widths in shared package note_seq_pkg.
REQ-024 SHALL implement note storage as sub-module note_mem: DEPTH x (PITCH_W+DUR_W+1), one synchronous write port, one asynchronous read port.

Verification
REQ-025 Write notes {199,4,0},{177,2,1}, GAP_TICKS=0, start -> tone_restart at start+2 cycles with pitch_o=199; pitch_o=177 after 4 fs_ticks; done after 2 more ticks; busy=0.
REQ-026 Same program with loop_en=1 -> after note 1, cur_idx=0 and pitch_o=199 again, with no done pulse.
REQ-027 Note {0,3,1} -> mute_o=1 throughout PLAY; done after 3 ticks.
REQ-028 GAP_TICKS=8, two notes -> mute_o=1 for exactly 8 fs_ticks between the notes.
REQ-029 stop asserted mid-PLAY together with start and fs_tick -> IDLE next cycle, pitch_o=511, no done pulse; reset mid-GAP -> all outputs at reset values.
REQ-030 All 32 entries with last=0 -> wrap handled at index 31 (done, or loop to 0); a write to the active index takes effect only on its next LOAD.
